// File: rtl/case_9_sdiv_pkg.sv
// case_9_sdiv_pkg: shared FSM state type and default operand widths for the sequential signed divider.
package case_9_sdiv_pkg;
  localparam int DIN0_W = 6;
  localparam int DIN1_W = 2;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/case_9_sdiv_step.sv
// case_9_sdiv_step: one radix-2 restoring division step on unsigned magnitudes.
module case_9_sdiv_step #(
  parameter int N = 6,
  parameter int M = 3
) (
  input  logic [M-1:0] rem_i,
  input  logic [N-1:0] quo_i,
  input  logic [M-1:0] div_i,
  output logic [M-1:0] rem_o,
  output logic [N-1:0] quo_o
);
  logic [M:0] sh;
  logic       ge;
  assign sh    = {rem_i, quo_i[N-1]};
  assign ge    = sh >= {1'b0, div_i};
  // the restored value always fits in M bits, so modular subtraction is exact
  assign rem_o = sh[M-1:0] - (ge ? div_i : '0);
  assign quo_o = {quo_i[N-2:0], ge};
endmodule

// File: rtl/case_9_sdiv_6s_2s_seq.sv
// case_9_sdiv_6s_2s_seq: multi-cycle signed divider with C truncation semantics and fixed latency.
module case_9_sdiv_6s_2s_seq
  import case_9_sdiv_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic [din0_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero,
  output logic                  ovf
);
  localparam int W0 = din0_WIDTH;
  localparam int W1 = din1_WIDTH;
  localparam int CW = $clog2(W0);
  state_t        state_q, state_d;
  logic [W0:0]   m0, a_q;
  logic [W1:0]   m1, b_q, r_q, r_nx;
  logic [W0-1:0] q_nx, quot_q;
  logic [W1-1:0] lo_q, rem_q;
  logic [CW-1:0] cnt_q;
  logic          s0_q, neg_q, z_q, dz_q, ovf_q;
  // one bit wider so the most-negative operand has an exact magnitude
  assign m0 = din0[W0-1] ? -{din0[W0-1], din0} : {din0[W0-1], din0};
  assign m1 = din1[W1-1] ? -{din1[W1-1], din1} : {din1[W1-1], din1};
  case_9_sdiv_step #(.N(W0), .M(W1 + 1)) u_step (
    .rem_i(r_q),
    .quo_i(a_q[W0-1:0]),
    .div_i(b_q),
    .rem_o(r_nx),
    .quo_o(q_nx)
  );
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ap_start ? CALC : IDLE;
      CALC:    state_d = (cnt_q == CW'(W0 - 1)) ? FIX : CALC;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ap_idle = state_q == IDLE;
    ap_done = state_q == DONE;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      s0_q   <= 1'b0;
      neg_q  <= 1'b0;
      z_q    <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == IDLE && ap_start) begin
      a_q   <= m0;
      b_q   <= m1;
      r_q   <= '0;
      lo_q  <= din0[W1-1:0];
      cnt_q <= '0;
      s0_q  <= din0[W0-1];
      neg_q <= din0[W0-1] ^ din1[W1-1];
      z_q   <= din1 == '0;
    end else if (state_q == CALC) begin
      a_q   <= {1'b0, q_nx};
      r_q   <= r_nx;
      cnt_q <= cnt_q + 1'b1;
    end else if (state_q == FIX) begin
      quot_q <= z_q ? '1 : neg_q ? -a_q[W0-1:0] : a_q[W0-1:0];
      rem_q  <= z_q ? lo_q : s0_q ? -r_q[W1-1:0] : r_q[W1-1:0];
      dz_q   <= z_q;
      // a non-negative quotient with its top bit set exceeds the signed range
      ovf_q  <= !z_q && (a_q[W0] || (!neg_q && a_q[W0-1]));
    end
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dz_q;
  assign ovf         = ovf_q;
endmodule

// File: tb/tb_case_9_sdiv_6s_2s_seq.sv
// tb_case_9_sdiv_6s_2s_seq: directed vectors, corner sequences and randomized ops against an arithmetic model.
module tb_case_9_sdiv_6s_2s_seq;
  logic       ap_clk = 1'b0;
  logic       ap_rst_n = 1'b0;
  logic       ap_start = 1'b0;
  logic [5:0] din0 = '0;
  logic [1:0] din1 = '0;
  logic       ap_idle, ap_done, div_by_zero, ovf;
  logic [5:0] quot;
  logic [1:0] rem;
  int errs = 0;
  int checks = 0;

  case_9_sdiv_6s_2s_seq dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .ap_start(ap_start),
    .din0(din0),
    .din1(din1),
    .ap_idle(ap_idle),
    .ap_done(ap_done),
    .quot(quot),
    .rem(rem),
    .div_by_zero(div_by_zero),
    .ovf(ovf)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [5:0] a;
    logic [1:0] b;
    logic [5:0] q;
    logic [1:0] r;
    logic       dz;
    logic       ov;
  } vec_t;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic run_op(input logic [5:0] a, input logic [1:0] b, output int lat);
    int w;
    w = 0;
    while (!ap_idle && w < 20) begin
      tick();
      w++;
    end
    din0 = a;
    din1 = b;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    lat = 1;
    while (!ap_done && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_res(input string n, input logic [5:0] q, input logic [1:0] r,
                           input logic dz, input logic ov, input int lat);
    chk({n, "_quot"}, int'(quot), int'(q));
    chk({n, "_rem"}, int'(rem), int'(r));
    chk({n, "_dz"}, int'(div_by_zero), int'(dz));
    chk({n, "_ovf"}, int'(ovf), int'(ov));
    chk({n, "_latency"}, lat, 8);
  endtask

  task automatic model(input logic [5:0] a, input logic [1:0] b, output logic [5:0] q,
                       output logic [1:0] r, output logic dz, output logic ov);
    int ai, bi, qi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) begin
      q = '1;
      r = a[1:0];
      dz = 1'b1;
      ov = 1'b0;
    end else begin
      qi = ai / bi;
      q = 6'(qi);
      r = 2'(ai % bi);
      dz = 1'b0;
      ov = (qi > 31) || (qi < -32);
    end
  endtask

  vec_t tbl[8];

  initial begin
    int lat, t, dn;
    int dones[$];
    logic [5:0] eq;
    logic [1:0] er;
    logic edz, eov;
    tbl[0] = '{6'd23, 2'b10, 6'b110101, 2'b01, 1'b0, 1'b0};
    tbl[1] = '{6'b101001, 2'b10, 6'd11, 2'b11, 1'b0, 1'b0};
    tbl[2] = '{6'b100000, 2'b01, 6'b100000, 2'b00, 1'b0, 1'b0};
    tbl[3] = '{6'b100000, 2'b11, 6'b100000, 2'b00, 1'b0, 1'b1};
    tbl[4] = '{6'd17, 2'b00, 6'b111111, 2'b01, 1'b1, 1'b0};
    tbl[5] = '{6'd7, 2'b01, 6'd7, 2'b00, 1'b0, 1'b0};
    tbl[6] = '{6'b111001, 2'b10, 6'd3, 2'b11, 1'b0, 1'b0};
    tbl[7] = '{6'd31, 2'b11, 6'b100001, 2'b00, 1'b0, 1'b0};

    #12;
    chk("reset_idle", int'(ap_idle), 1);
    chk("reset_done", int'(ap_done), 0);
    chk("reset_quot", int'(quot), 0);
    chk("reset_rem", int'(rem), 0);
    chk("reset_dz", int'(div_by_zero), 0);
    chk("reset_ovf", int'(ovf), 0);
    tick();
    ap_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, lat);
      check_res($sformatf("vec%0d", i), tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov, lat);
    end

    repeat (3) tick();
    chk("hold_quot", int'(quot), int'(tbl[7].q));
    chk("hold_idle", int'(ap_idle), 1);

    din0 = 6'd23;
    din1 = 2'b10;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    lat = 1;
    while (!ap_done && lat < 30) begin
      if (lat == 3) begin
        din0 = 6'b111011;
        din1 = 2'b01;
        ap_start = 1'b1;
      end else ap_start = 1'b0;
      tick();
      lat++;
    end
    ap_start = 1'b0;
    check_res("repulse", 6'b110101, 2'b01, 1'b0, 1'b0, lat);
    tick();
    chk("repulse_idle", int'(ap_idle), 1);
    dn = 0;
    repeat (10) begin
      tick();
      if (ap_done) dn++;
    end
    chk("repulse_no_second", dn, 0);

    din0 = 6'b101001;
    din1 = 2'b10;
    ap_start = 1'b1;
    tick();
    t = 1;
    while (dones.size() < 2 && t < 40) begin
      if (ap_done) begin
        dones.push_back(t);
        chk("held_quot", int'(quot), 11);
        chk("held_rem", int'(rem), 3);
      end
      if (dones.size() < 2) begin
        tick();
        t++;
      end
    end
    ap_start = 1'b0;
    chk("held_count", dones.size(), 2);
    if (dones.size() == 2) begin
      chk("held_first", dones[0], 8);
      chk("held_gap", dones[1] - dones[0], 9);
    end

    tick();
    tick();
    din0 = 6'd23;
    din1 = 2'b10;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    tick();
    tick();
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("rst_mid_idle", int'(ap_idle), 1);
    chk("rst_mid_quot", int'(quot), 0);
    chk("rst_mid_rem", int'(rem), 0);
    chk("rst_mid_done", int'(ap_done), 0);
    tick();
    ap_rst_n = 1'b1;
    dn = 0;
    repeat (12) begin
      tick();
      if (ap_done) dn++;
    end
    chk("rst_mid_no_done", dn, 0);
    run_op(6'd7, 2'b01, lat);
    check_res("after_rst", 6'd7, 2'b00, 1'b0, 1'b0, lat);

    for (int i = 0; i < 150; i++) begin
      logic [5:0] a;
      logic [1:0] b;
      a = 6'($urandom);
      b = 2'($urandom);
      if (i % 10 == 0) a = 6'b100000;
      model(a, b, eq, er, edz, eov);
      run_op(a, b, lat);
      check_res($sformatf("rand%0d_%0d_%0d", i, $signed(a), $signed(b)), eq, er, edz, eov, lat);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/case_9_sdiv_6s_2s_seq.md
CASE_9_SDIV_6S_2S_SEQ -- requirements
Module: case_9_sdiv_6s_2s_seq

Interface
REQ-001 SHALL have parameter ID, default 1, instance tag with no functional effect.
REQ-002 SHALL have parameter din0_WIDTH, default 6, signed dividend width, which is also the quotient width.
REQ-003 SHALL have parameter din1_WIDTH, default 2, signed divisor width, which is also the remainder width.
REQ-004 ap_clk  in  1  single clock; all state updates on the rising edge.
REQ-005 ap_rst_n  in  1  asynchronous, active-low reset.
REQ-006 ap_start  in  1  request; accepted only on a cycle where ap_idle=1.
REQ-007 din0  in  din0_WIDTH  signed dividend; sampled on the accept cycle.
REQ-008 din1  in  din1_WIDTH  signed divisor; sampled on the accept cycle.
REQ-009 ap_idle  out  1  high in IDLE, meaning ready to accept.
REQ-010 ap_done  out  1  one-cycle pulse; results valid on that cycle.
REQ-011 quot  out  din0_WIDTH  signed quotient.
REQ-012 rem  out  din1_WIDTH  signed remainder.
REQ-013 div_by_zero  out  1  set when the divisor sampled for the result was 0.
REQ-014 ovf  out  1  set when the true quotient is not representable in din0_WIDTH.

Function
REQ-015 SHALL implement a 4-state FSM: IDLE, CALC, FIX, DONE.
REQ-016 IDLE SHALL move to CALC when ap_start=1, latching din0 and din1, sign flags, and absolute values, with the iteration counter at 0.
REQ-017 CALC SHALL perform one radix-2 restoring step per cycle on the magnitudes.
REQ-018 CALC SHALL last exactly din0_WIDTH cycles, then move to FIX.
REQ-019 FIX SHALL apply C truncation semantics: quotient negated if the operand signs differ; remainder takes the dividend's sign.
REQ-020 FIX SHALL register quot, rem, div_by_zero and ovf, then move to DONE.
REQ-021 DONE SHALL assert ap_done for one cycle and return to IDLE.
REQ-022 Latency SHALL be fixed: ap_done is high on cycle k+din0_WIDTH+2 after an accept on cycle k, i.e. 8 cycles at the defaults, independent of operand values.
REQ-023 quot, rem and the flags SHALL hold their values from one ap_done until the next FIX update.
REQ-024 ap_start outside IDLE SHALL be ignored; no queuing.
REQ-025 Back-to-back operation: ap_start held high SHALL be re-accepted on the IDLE cycle following DONE.
REQ-026 Divisor 0 SHALL yield quot = all ones (-1), rem = low din1_WIDTH bits of the dividend, div_by_zero=1, ovf=0.
REQ-027 Most-negative dividend divided by -1 SHALL yield quot wrapped to the most-negative value, rem=0, ovf=1.
REQ-028 Magnitudes SHALL be computed one bit wider than the operands, so the most-negative operand values are exact.

Reset
REQ-029 Asserting ap_rst_n=0 SHALL immediately force IDLE, regardless of clock.
REQ-030 Reset SHALL force ap_idle=1, ap_done=0, quot=0, rem=0, div_by_zero=0, ovf=0 and clear all working registers.
REQ-031 Reset mid-CALC SHALL abandon the operation with no ap_done pulse.
REQ-032 The first accept after reset deassertion SHALL behave identically to any other accept.

Structure
REQ-033 Package case_9_sdiv_pkg SHALL hold the state enum and the default width constants.
REQ-034 A single combinational sub-module, case_9_sdiv_step, SHALL implement one restoring iteration (shift, trial subtract, quotient bit).
REQ-035 The FSM, counter and sign fixup SHALL live in the top module.

Verification
REQ-036 din0=23, din1=-2 -> quot=-11, rem=1, flags 0, ap_done exactly 8 cycles after accept.
REQ-037 din0=-23, din1=-2 -> quot=11, rem=-1; and din0=-32, din1=1 -> quot=-32, rem=0.
REQ-038 din0=-32, din1=-1 -> quot=-32, rem=0, ovf=1.
REQ-039 din0=17, din1=0 -> quot=-1, rem=1, div_by_zero=1, latency still 8.
REQ-040 ap_start re-pulsed during CALC -> ignored, results unchanged; ap_start held high -> two results, 9 cycles apart.
REQ-041 ap_rst_n pulsed low during CALC cycle 3 -> no ap_done, outputs zero, ap_idle=1; next op (7 / 1) -> quot=7, rem=0.
